universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 97 +++++++++
 tb/tb_universal_shift_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load.
// Define USR_WORD_CNT_EN to add the shift counter and the word_done pulse.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register contents; en=0 or hold mode keeps the current value.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_RIGHT: q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_LEFT:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_LOAD:  q_d = d;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

`ifdef USR_WORD_CNT_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             word_done_q;
  logic             word_done_d;
  logic             shift_c;
  logic             load_c;

  assign shift_c = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));
  assign load_c  = en && (mode == MODE_LOAD);

  // Count shifts in either direction; the WIDTH-th shift wraps and pulses word_done.
  always_comb begin
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    if (shift_c) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d       = '0;
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (load_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign word_done = word_done_q;
`else
  assign word_done = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=4): arithmetic reference
// model checked every cycle plus directed literal expectations.
module tb_universal_shift_reg;

  localparam int unsigned W = 4;
`ifdef USR_WORD_CNT_EN
  localparam bit WC = 1'b1;
`else
  localparam bit WC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic         word_done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: register value as an integer, shifts since reset/load.
  int unsigned m_q      = 0;
  int unsigned m_shifts = 0;
  bit          m_wd     = 1'b0;
  bit          m_valid  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance the model by the same rules.
  task automatic step(input bit r, input bit e, input bit [1:0] m,
                      input bit sr, input bit sl, input bit [W-1:0] dd);
    @(negedge clk);
    rst_n = r; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
    @(posedge clk);
    if (!r) begin
      m_q = 0; m_shifts = 0; m_wd = 1'b0;
    end else if (!e || m == 2'd0) begin
      m_wd = 1'b0;
    end else if (m == 2'd3) begin
      m_q = int'(dd); m_shifts = 0; m_wd = 1'b0;
    end else begin
      if (m == 2'd1) m_q = (m_q / 2) + (sr ? (2 ** (W - 1)) : 0);
      else           m_q = ((m_q * 2) % (2 ** W)) + (sl ? 1 : 0);
      m_shifts++;
      m_wd = WC && ((m_shifts % W) == 0);
    end
    m_valid = 1'b1;
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", 32'(q), 32'(m_q));
      check("model_sout_r", 32'(sout_r), 32'(m_q % 2));
      check("model_sout_l", 32'(sout_l), 32'(m_q / (2 ** (W - 1))));
      check("model_word_done", 32'(word_done), 32'(m_wd));
    end
  end

  logic [3:0] exp_r [4];
  logic [3:0] sin_seq [7];
  logic [3:0] exp_l [4];

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; sin_r = 1'b0; sin_l = 1'b0; d = '0;

    // Reset then parallel load
    step(0, 1, 2'd3, 0, 0, 4'b1111);
    step(0, 1, 2'd3, 0, 0, 4'b1111);
    check("reset_q", 32'(q), 32'h0);
    check("reset_wd", 32'(word_done), 32'h0);
    step(1, 1, 2'd3, 0, 0, 4'b1011);
    check("load_q", 32'(q), 32'hb);
    check("load_sout_r", 32'(sout_r), 32'h1);
    check("load_sout_l", 32'(sout_l), 32'h1);

    // Shift right a full word with sin_r=0
    exp_r[0] = 4'b0101; exp_r[1] = 4'b0010; exp_r[2] = 4'b0001; exp_r[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'd1, 0, 0, '0);
      check("shr_q", 32'(q), 32'(exp_r[i]));
      check("shr_wd", 32'(word_done), (i == 3) ? 32'(WC) : 32'h0);
    end
    step(1, 1, 2'd0, 1, 1, 4'b1111);
    check("hold_mode_q", 32'(q), 32'h0);
    check("wd_one_cycle", 32'(word_done), 32'h0);

    // Serial in to serial out latency
    sin_seq[0] = 1; sin_seq[1] = 0; sin_seq[2] = 1; sin_seq[3] = 0;
    sin_seq[4] = 0; sin_seq[5] = 0; sin_seq[6] = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 2'd1, sin_seq[i][0], 0, '0);
      if (i >= 3) check("latency_sout_r", 32'(sout_r), 32'(sin_seq[i - 3][0]));
    end

    // Hold inside a word pauses the count
    step(1, 1, 2'd3, 0, 0, 4'b0000);
    step(1, 1, 2'd1, 1, 0, '0);
    step(1, 1, 2'd1, 1, 0, '0);
    check("pre_hold_q", 32'(q), 32'hc);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2'd3, 0, 0, 4'b1111);
      check("en_low_q", 32'(q), 32'hc);
      check("en_low_wd", 32'(word_done), 32'h0);
    end
    step(1, 1, 2'd1, 0, 0, '0);
    check("post_hold_wd3", 32'(word_done), 32'h0);
    step(1, 1, 2'd1, 0, 0, '0);
    check("post_hold_q", 32'(q), 32'h3);
    check("post_hold_wd4", 32'(word_done), 32'(WC));

    // Three shifts then a load: no pulse, count restarts
    for (int i = 0; i < 3; i++) step(1, 1, 2'd2, 0, 0, '0);
    check("pre_load_q", 32'(q), 32'h8);
    step(1, 1, 2'd3, 0, 0, 4'b0101);
    check("midload_q", 32'(q), 32'h5);
    check("midload_wd", 32'(word_done), 32'h0);
    exp_l[0] = 4'b1011; exp_l[1] = 4'b0111; exp_l[2] = 4'b1111; exp_l[3] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'd2, 0, 1, '0);
      check("after_load_q", 32'(q), 32'(exp_l[i]));
      check("after_load_wd", 32'(word_done), (i == 3) ? 32'(WC) : 32'h0);
    end

    // Reset mid-word discards the partial count
    for (int i = 0; i < 3; i++) step(1, 1, 2'd2, 0, 1, '0);
    step(0, 1, 2'd2, 0, 1, '0);
    check("midreset_q", 32'(q), 32'h0);
    check("midreset_wd", 32'(word_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd2, 0, 1, '0);
      check("post_reset_wd", 32'(word_done), 32'h0);
    end
    check("post_reset_q", 32'(q), 32'h7);
    step(1, 1, 2'd2, 0, 1, '0);
    check("post_reset_wd4", 32'(word_done), 32'(WC));

    // Direction change mid-word keeps counting
    step(1, 1, 2'd1, 0, 0, '0);
    step(1, 1, 2'd1, 0, 0, '0);
    step(1, 1, 2'd2, 0, 0, '0);
    check("dirchg_wd3", 32'(word_done), 32'h0);
    step(1, 1, 2'd2, 0, 0, '0);
    check("dirchg_q", 32'(q), 32'hc);
    check("dirchg_wd4", 32'(word_done), 32'(WC));

    step(1, 0, 2'd0, 0, 0, '0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
